// File: rtl/sio_fifo_ctrl.sv
// Buffered front-end for the sio SPI master: TX/RX word FIFOs plus a launch sequencer.
// Latency: TX write to launch 1 cycle; back-to-back launches every 2*(bits+1)+4 cycles.
// Backpressure: holds in IDLE while RX is full, TX is empty or enable is low; full-TX writes drop.

// Circular word buffer with level counter and a first-word-fall-through head (0 when empty).
// Latency: flags, level and head update one cycle after the push/pop edge.
// Backpressure: a push on a full buffer is dropped unless a valid pop happens in the same cycle.
module sio_fifo_ctrl_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 16,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clkin,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_ok;
  logic          push_ok;

  // A pop on an empty buffer is ignored even if a push lands in the same cycle.
  assign pop_ok  = pop && (level != '0);
  assign push_ok = push && ((level != FULL_LVL) || pop_ok);

  always_ff @(posedge clkin) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop_ok)      level <= level + LW'(1);
      else if (pop_ok && !push_ok) level <= level - LW'(1);
    end
  end

  always_ff @(posedge clkin) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  assign full     = (level == FULL_LVL);
  assign empty    = (level == '0);
  assign head_dat = empty ? '0 : mem[rd_ptr];
endmodule

module sio_fifo_ctrl #(
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clkin,
  input  logic          rst,
  input  logic          enable,
  input  logic [3:0]    bits_cfg,
  input  logic          tx_wr,
  input  logic [15:0]   tx_data,
  output logic          tx_full,
  output logic [LW-1:0] tx_level,
  input  logic          rx_rd,
  output logic [15:0]   rx_data,
  output logic          rx_empty,
  output logic [LW-1:0] rx_level,
  output logic          busy,
  output logic          err,
  input  logic          clr_err,
  output logic          go,
  output logic [15:0]   data_i,
  output logic [3:0]    bits,
  input  logic          sio_state,
  input  logic [15:0]   sio_data_o
);
  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

  state_t      state_q;
  state_t      state_d;
  logic        launch;
  logic        rx_push;
  logic        tx_empty;
  logic        rx_full;
  logic [15:0] tx_head;
  logic        err_set;

  sio_fifo_ctrl_fifo #(.DEPTH(DEPTH), .W(16), .LW(LW)) u_tx_fifo (
    .clkin    (clkin),
    .rst      (rst),
    .push     (tx_wr),
    .push_dat (tx_data),
    .pop      (launch),
    .head_dat (tx_head),
    .full     (tx_full),
    .empty    (tx_empty),
    .level    (tx_level)
  );

  sio_fifo_ctrl_fifo #(.DEPTH(DEPTH), .W(16), .LW(LW)) u_rx_fifo (
    .clkin    (clkin),
    .rst      (rst),
    .push     (rx_push),
    .push_dat (sio_data_o),
    .pop      (rx_rd),
    .head_dat (rx_data),
    .full     (rx_full),
    .empty    (rx_empty),
    .level    (rx_level)
  );

  always_ff @(posedge clkin) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Launch only with a free RX slot, so the DONE push can never overflow.
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    rx_push = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && !tx_empty && !rx_full) begin
          launch  = 1'b1;
          state_d = START;
        end
      end
      START: if (sio_state)  state_d = RUN;
      RUN:   if (!sio_state) state_d = DONE;
      DONE: begin
        rx_push = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // data_i and bits stay put between launches; sio reads data_i for the whole transfer.
  always_ff @(posedge clkin) begin
    if (rst) begin
      go     <= 1'b0;
      data_i <= '0;
      bits   <= '0;
    end else begin
      go <= launch;
      if (launch) begin
        data_i <= tx_head;
        bits   <= bits_cfg;
      end
    end
  end

  // A write accepted alongside a launch pop is not an overflow.
  assign err_set = (tx_wr && tx_full && !launch) || (rx_rd && rx_empty);

  always_ff @(posedge clkin) begin
    if (rst) err <= 1'b0;
    else     err <= err_set | (err & ~clr_err);
  end

  assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_sio_fifo_ctrl.sv
// Bench for sio_fifo_ctrl with a loop-back sio model; expected words come from a queue model.
module tb_sio_fifo_ctrl;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clkin = 1'b0;
  logic          rst;
  logic          enable;
  logic [3:0]    bits_cfg;
  logic          tx_wr;
  logic [15:0]   tx_data;
  logic          tx_full;
  logic [LW-1:0] tx_level;
  logic          rx_rd;
  logic [15:0]   rx_data;
  logic          rx_empty;
  logic [LW-1:0] rx_level;
  logic          busy;
  logic          err;
  logic          clr_err;
  logic          go;
  logic [15:0]   data_i;
  logic [3:0]    bits;
  logic          sio_state;
  logic [15:0]   sio_data_o;

  int checks = 0;
  int failures = 0;
  int go_cnt = 0;
  int go_wide = 0;
  int cyc = 0;
  int launch_t[$];
  logic go_prev = 1'b0;
  logic [15:0] exp_q[$];
  int sio_cnt;

  sio_fifo_ctrl #(.DEPTH(DEPTH), .LW(LW)) dut (
    .clkin(clkin), .rst(rst), .enable(enable), .bits_cfg(bits_cfg),
    .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full), .tx_level(tx_level),
    .rx_rd(rx_rd), .rx_data(rx_data), .rx_empty(rx_empty), .rx_level(rx_level),
    .busy(busy), .err(err), .clr_err(clr_err), .go(go), .data_i(data_i),
    .bits(bits), .sio_state(sio_state), .sio_data_o(sio_data_o)
  );

  always #5 clkin = ~clkin;

  function automatic logic [15:0] mask_of(input int b);
    int m;
    m = (1 << (b + 1)) - 1;
    return m[15:0];
  endfunction

  // Behavioural sio: state high 2*(bits+1) cycles, MISO looped back to MOSI.
  always @(posedge clkin) begin
    if (rst) begin
      sio_state  <= 1'b0;
      sio_cnt    <= 0;
      sio_data_o <= '0;
    end else if (!sio_state) begin
      if (go) begin
        sio_state <= 1'b1;
        sio_cnt   <= 2 * (int'(bits) + 1) - 1;
      end
    end else if (sio_cnt != 0) begin
      sio_cnt <= sio_cnt - 1;
    end else begin
      sio_state  <= 1'b0;
      sio_data_o <= data_i & mask_of(int'(bits));
    end
  end

  always @(posedge clkin) begin
    cyc = cyc + 1;
    if (go) begin
      go_cnt = go_cnt + 1;
      launch_t.push_back(cyc);
    end
    if (go && go_prev) go_wide = go_wide + 1;
    go_prev = go;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; bits_cfg = '0; tx_wr = 1'b0; tx_data = '0;
    rx_rd = 1'b0; clr_err = 1'b0;
    tick(); tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic write_word(input logic [15:0] w);
    tx_wr = 1'b1; tx_data = w;
    tick();
    tx_wr = 1'b0;
  endtask

  task automatic wait_rx_level(input int lvl, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (int'(rx_level) == lvl) begin ok = 1'b1; break; end
      tick();
    end
    if (int'(rx_level) == lvl) ok = 1'b1;
  endtask

  task automatic pop_check(input string nm);
    logic [15:0] e;
    e = exp_q.pop_front();
    checks++;
    if (rx_data !== e) begin
      failures++;
      $display("FAIL %s: rx_data=%h expected=%h", nm, rx_data, e);
    end
    rx_rd = 1'b1;
    tick();
    rx_rd = 1'b0;
  endtask

  task automatic test_reset();
    int g0;
    do_reset();
    checks++;
    if ({go, data_i, bits, busy, err, tx_full, tx_level, rx_empty, rx_level, rx_data} !==
        {1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, {LW{1'b0}}, 1'b1, {LW{1'b0}}, 16'h0}) begin
      failures++;
      $display("FAIL reset_values: go=%b data_i=%h bits=%h busy=%b err=%b full=%b txl=%0d empty=%b rxl=%0d rxd=%h required all zero except rx_empty=1",
               go, data_i, bits, busy, err, tx_full, tx_level, rx_empty, rx_level, rx_data);
    end
    g0 = go_cnt;
    repeat (50) tick();
    checks++;
    if (go_cnt != g0) begin
      failures++;
      $display("FAIL reset_no_go: go pulses=%0d required 0", go_cnt - g0);
    end
  endtask

  task automatic test_single_byte();
    int g0, w0, i;
    g0 = go_cnt; w0 = go_wide;
    enable = 1'b1; bits_cfg = 4'd7;
    write_word(16'h00A5);
    tick();
    checks++;
    if (go !== 1'b1 || data_i !== 16'h00A5 || bits !== 4'd7) begin
      failures++;
      $display("FAIL single_launch: go=%b data_i=%h bits=%0d required 1/00a5/7", go, data_i, bits);
    end
    tick();
    checks++;
    if (go !== 1'b0) begin
      failures++;
      $display("FAIL single_go_pulse: go=%b required 0", go);
    end
    for (i = 0; i < 40 && sio_state; i++) tick();
    checks++;
    if (sio_state !== 1'b0) begin
      failures++;
      $display("FAIL single_sio_timeout: sio_state=%b required 0", sio_state);
    end
    tick();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL single_busy_done: busy=%b required 1", busy);
    end
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || rx_data !== 16'h00A5 || rx_level !== LW'(1)) begin
      failures++;
      $display("FAIL single_result: busy=%b rx_data=%h rx_level=%0d required 0/00a5/1", busy, rx_data, rx_level);
    end
    checks++;
    if (go_cnt - g0 != 1 || go_wide != w0) begin
      failures++;
      $display("FAIL single_go_count: pulses=%0d wide=%0d required 1/0", go_cnt - g0, go_wide - w0);
    end
    rx_rd = 1'b1; tick(); rx_rd = 1'b0;
    checks++;
    if (rx_empty !== 1'b1 || rx_data !== 16'h0 || err !== 1'b0) begin
      failures++;
      $display("FAIL single_pop: rx_empty=%b rx_data=%h err=%b required 1/0000/0", rx_empty, rx_data, err);
    end
  endtask

  task automatic burst(input int b, input int n, input logic [15:0] words[4], input string nm);
    int s0;
    bit ok;
    s0 = launch_t.size();
    bits_cfg = 4'(b); enable = 1'b1;
    for (int i = 0; i < n; i++) begin
      write_word(words[i]);
      exp_q.push_back(words[i] & mask_of(b));
    end
    checks++;
    if (tx_level !== LW'(n - 1)) begin
      failures++;
      $display("FAIL %s_tx_level: tx_level=%0d required %0d", nm, tx_level, n - 1);
    end
    wait_rx_level(n, 400, ok);
    checks++;
    if (!ok || tx_level !== '0) begin
      failures++;
      $display("FAIL %s_drain: rx_level=%0d tx_level=%0d required %0d/0", nm, rx_level, tx_level, n);
    end
    for (int i = 0; i + 1 < n; i++) begin
      checks++;
      if (launch_t.size() < s0 + i + 2 ||
          launch_t[s0 + i + 1] - launch_t[s0 + i] != 2 * (b + 1) + 4) begin
        failures++;
        $display("FAIL %s_spacing%0d: launches seen=%0d required interval %0d",
                 nm, i, launch_t.size() - s0, 2 * (b + 1) + 4);
      end
    end
    for (int i = 0; i < n; i++) pop_check(nm);
  endtask

  task automatic test_burst();
    logic [15:0] w[4];
    w[0] = 16'h1234; w[1] = 16'hBEEF; w[2] = 16'h0001; w[3] = 16'hFFFF;
    burst(15, 4, w, "burst16");
  endtask

  task automatic test_back_to_back();
    logic [15:0] w[4];
    w[0] = 16'h12C3; w[1] = 16'h0F5A; w[2] = 16'hAA81; w[3] = 16'h0;
    burst(7, 3, w, "b2b8");
  endtask

  task automatic test_full_overflow();
    bit ok;
    int g0;
    do_reset();
    g0 = go_cnt;
    for (int i = 0; i <= DEPTH; i++) write_word(16'h0100 + 16'(i));
    checks++;
    if (tx_full !== 1'b1 || tx_level !== LW'(DEPTH) || err !== 1'b1 || go_cnt != g0) begin
      failures++;
      $display("FAIL full_flags: full=%b level=%0d err=%b pulses=%0d required 1/%0d/1/0",
               tx_full, tx_level, err, go_cnt - g0, DEPTH);
    end
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL clr_err: err=%b required 0", err);
    end
    clr_err = 1'b1; tx_wr = 1'b1; tx_data = 16'hDEAD; tick();
    clr_err = 1'b0; tx_wr = 1'b0;
    checks++;
    if (err !== 1'b1 || tx_level !== LW'(DEPTH)) begin
      failures++;
      $display("FAIL clr_vs_set: err=%b tx_level=%0d required 1/%0d", err, tx_level, DEPTH);
    end
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(16'h0100 + 16'(i));
    bits_cfg = 4'd15; enable = 1'b1;
    wait_rx_level(DEPTH, 1000, ok);
    checks++;
    if (!ok || tx_level !== '0) begin
      failures++;
      $display("FAIL full_drain: rx_level=%0d tx_level=%0d required %0d/0", rx_level, tx_level, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) pop_check("full_words");
    repeat (50) tick();
    checks++;
    if (rx_empty !== 1'b1 || go_cnt - g0 != DEPTH) begin
      failures++;
      $display("FAIL full_extra_absent: rx_empty=%b launches=%0d required 1/%0d", rx_empty, go_cnt - g0, DEPTH);
    end
    rx_rd = 1'b1; tick(); rx_rd = 1'b0;
    checks++;
    if (err !== 1'b1 || rx_empty !== 1'b1) begin
      failures++;
      $display("FAIL empty_read_err: err=%b rx_empty=%b required 1/1", err, rx_empty);
    end
    clr_err = 1'b1; tick(); clr_err = 1'b0;
  endtask

  task automatic test_rx_backpressure();
    bit ok;
    int g0;
    logic [15:0] w;
    do_reset();
    g0 = go_cnt;
    bits_cfg = 4'd0; enable = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      w = 16'($urandom);
      write_word(w);
      exp_q.push_back(w & 16'h1);
    end
    wait_rx_level(DEPTH, 300, ok);
    repeat (40) tick();
    checks++;
    if (!ok || go_cnt - g0 != DEPTH || tx_level !== LW'(2) || busy !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL rx_bp_hold: launches=%0d tx_level=%0d busy=%b err=%b required %0d/2/0/0",
               go_cnt - g0, tx_level, busy, err, DEPTH);
    end
    pop_check("rx_bp_word");
    repeat (30) tick();
    checks++;
    if (go_cnt - g0 != DEPTH + 1 || tx_level !== LW'(1) || rx_level !== LW'(DEPTH)) begin
      failures++;
      $display("FAIL rx_bp_resume: launches=%0d tx_level=%0d rx_level=%0d required %0d/1/%0d",
               go_cnt - g0, tx_level, rx_level, DEPTH + 1, DEPTH);
    end
  endtask

  task automatic test_reset_mid_transfer();
    int g0, i;
    do_reset();
    bits_cfg = 4'd15; enable = 1'b1;
    write_word(16'h5A5A);
    write_word(16'hC3C3);
    for (i = 0; i < 30 && !(busy && sio_state); i++) tick();
    repeat (5) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if (tx_level !== '0 || rx_level !== '0 || go !== 1'b0 || busy !== 1'b0 || rx_empty !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid: txl=%0d rxl=%0d go=%b busy=%b rx_empty=%b required 0/0/0/0/1",
               tx_level, rx_level, go, busy, rx_empty);
    end
    g0 = go_cnt;
    repeat (80) tick();
    checks++;
    if (rx_level !== '0 || go_cnt != g0) begin
      failures++;
      $display("FAIL reset_mid_after: rx_level=%0d pulses=%0d required 0/0", rx_level, go_cnt - g0);
    end
  endtask

  task automatic test_random();
    int b, lim;
    logic [15:0] w;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      b = $urandom_range(0, 15);
      bits_cfg = 4'(b);
      for (int c = 0; c < 300; c++) begin
        enable = ($urandom_range(0, 7) != 0);
        w = 16'($urandom);
        tx_data = w;
        tx_wr = !tx_full && ($urandom_range(0, 2) == 0);
        if (tx_wr) exp_q.push_back(w & mask_of(b));
        if (!rx_empty && $urandom_range(0, 1) == 1) begin
          tx_wr = tx_wr;
          pop_check("random_word");
          tx_wr = 1'b0;
        end else begin
          tick();
        end
      end
      tx_wr = 1'b0; enable = 1'b1;
      lim = 0;
      while (exp_q.size() != 0 && lim < 3000) begin
        if (!rx_empty) pop_check("random_drain");
        else tick();
        lim++;
      end
      checks++;
      if (exp_q.size() != 0 || err !== 1'b0 || tx_level !== '0) begin
        failures++;
        $display("FAIL random_round%0d: left=%0d err=%b tx_level=%0d required 0/0/0",
                 r, exp_q.size(), err, tx_level);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst();
    test_back_to_back();
    test_full_overflow();
    test_rx_backpressure();
    test_reset_mid_transfer();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
